// File: rtl/mutative_predictor_pkg.sv
// Shared types for the mutative cache policy stage: predictor FSM states,
// epoch verdicts and the highest legal setup level.
package mutative_types;

    typedef enum logic [1:0] {
        P_COUNT,
        P_DECIDE,
        P_REQ,
        P_COOL
    } predictor_state_t;

    typedef enum logic [1:0] {
        V_NONE,
        V_RAISE,
        V_LOWER
    } verdict_t;

    localparam logic [1:0] SETUP_MAX = 2'd3;

endpackage

// File: rtl/mutative_sat_counter.sv
// Saturating up-counter with synchronous clear; clr together with inc
// restarts the count at 1 instead of 0.
module mutative_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= inc ? WIDTH'(1) : '0;
        end else if (inc && (value != WIDTH'(MAX))) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/mutative_predictor.sv
// Epoch-based miss monitor that asks the flush/setup controller to raise or
// lower the cache setup level through a valid/ready handshake.
module mutative_predictor
    import mutative_types::*;
#(
    parameter int EPOCH_LEN = 256,
    parameter int MISS_HI   = 64,
    parameter int MISS_LO   = 8,
    parameter int HYST      = 2,
    parameter int COOLDOWN  = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         acc_valid,
    input  logic                         acc_hit,
    input  logic                         flush_stall,
    input  logic [1:0]                   setup,
    input  logic                         setup_ready,
    output logic                         setup_valid,
    output logic                         setup_update,
    output logic [$clog2(EPOCH_LEN):0]   epoch_misses
);

    localparam int CW     = $clog2(EPOCH_LEN) + 1;
    localparam int COOL_W = $clog2(COOLDOWN + 1);

    predictor_state_t    state, next_state;
    verdict_t            verdict, last_verdict;
    logic [CW-1:0]       acc_cnt, miss_cnt;
    logic [3:0]          streak, streak_next;
    logic [COOL_W-1:0]   cool_cnt;
    logic                count_en, epoch_close, deciding, handshake;
    logic                streak_restart, request;

    assign count_en    = acc_valid & ~flush_stall & (state == P_COUNT);
    assign epoch_close = count_en & (acc_cnt == CW'(EPOCH_LEN - 1));
    assign deciding    = (state == P_DECIDE);
    assign handshake   = (state == P_REQ) & setup_valid & setup_ready;

    mutative_sat_counter #(.WIDTH(CW), .MAX(EPOCH_LEN)) u_acc_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (count_en),
        .clr   (deciding),
        .value (acc_cnt)
    );

    mutative_sat_counter #(.WIDTH(CW), .MAX(EPOCH_LEN)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (count_en & ~acc_hit),
        .clr   (deciding),
        .value (miss_cnt)
    );

    // A repeated non-NONE verdict extends the streak; anything else restarts it.
    mutative_sat_counter #(.WIDTH(4), .MAX(15)) u_streak (
        .clk   (clk),
        .rst   (rst),
        .inc   (deciding & (verdict != V_NONE)),
        .clr   ((deciding & streak_restart) | handshake),
        .value (streak)
    );

    always_comb begin
        verdict = V_NONE;
        if ((miss_cnt >= CW'(MISS_HI)) && (setup != SETUP_MAX)) begin
            verdict = V_RAISE;
        end else if ((miss_cnt <= CW'(MISS_LO)) && (setup != 2'd0)) begin
            verdict = V_LOWER;
        end
    end

    // Hysteresis is judged on the streak value this decision will leave behind.
    always_comb begin
        streak_restart = (verdict == V_NONE) || (verdict != last_verdict);
        streak_next    = streak;
        if (streak_restart) begin
            streak_next = {3'b000, verdict != V_NONE};
        end else if (streak != 4'd15) begin
            streak_next = streak + 4'd1;
        end
        request = deciding && (streak_next >= 4'(HYST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= P_COUNT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            P_COUNT:  if (epoch_close) next_state = P_DECIDE;
            P_DECIDE: next_state = request ? P_REQ : P_COUNT;
            P_REQ:    if (handshake) next_state = P_COOL;
            P_COOL:   if (cool_cnt == '0) next_state = P_COUNT;
            default:  next_state = P_COUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            setup_valid  <= 1'b0;
            setup_update <= 1'b0;
            epoch_misses <= '0;
            last_verdict <= V_NONE;
            cool_cnt     <= '0;
        end else begin
            if (deciding) begin
                epoch_misses <= miss_cnt;
                last_verdict <= verdict;
            end
            if (request) begin
                setup_valid  <= 1'b1;
                setup_update <= (verdict == V_RAISE);
            end
            if (handshake) begin
                setup_valid <= 1'b0;
                cool_cnt    <= COOL_W'(COOLDOWN - 1);
            end else if ((state == P_COOL) && (cool_cnt != '0)) begin
                cool_cnt <= cool_cnt - 1'b1;
            end
        end
    end

endmodule
